// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, ALU one-hot bit indices and bypass helper
package riscv_pkg;

  localparam int XLEN   = 64;
  localparam int CTRL_W = 17;
  localparam int REG_AW = 5;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLL  = 2;
  localparam int OP_SLT  = 3;
  localparam int OP_SLTU = 4;
  localparam int OP_XOR  = 5;
  localparam int OP_SRL  = 6;
  localparam int OP_SRA  = 7;
  localparam int OP_OR   = 8;
  localparam int OP_AND  = 9;
  localparam int OP_LUI  = 10;
  localparam int OP_BEQ  = 11;
  localparam int OP_BNE  = 12;
  localparam int OP_BLT  = 13;
  localparam int OP_BGE  = 14;
  localparam int OP_BLTU = 15;
  localparam int OP_BGEU = 16;

  // x0 is hardwired to zero, so a write to it never counts as a producer.
  function automatic logic addr_hit(input logic [REG_AW-1:0] addr,
                                    input logic [REG_AW-1:0] src_addr,
                                    input logic              src_wen);
    return src_wen && (addr == src_addr) && (addr != '0);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - resolves one source operand against EX/MEM and MEM/WB bypass
module fwd_mux #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [riscv_pkg::REG_AW-1:0] addr,
  input  logic [XLEN-1:0]              id_data,
  input  logic [riscv_pkg::REG_AW-1:0] mem_addr,
  input  logic                         mem_wen,
  input  logic [XLEN-1:0]              mem_data,
  input  logic [riscv_pkg::REG_AW-1:0] wb_addr,
  input  logic                         wb_wen,
  input  logic [XLEN-1:0]              wb_data,
  output logic [XLEN-1:0]              data
);
  import riscv_pkg::*;

  // The younger producer (MEM) wins over the older one (WB).
  always_comb begin
    data = id_data;
    if (addr_hit(addr, mem_addr, mem_wen))
      data = mem_data;
    else if (addr_hit(addr, wb_addr, wb_wen))
      data = wb_data;
  end

endmodule

// File: rtl/ex_issue_stage.sv
// rtl/ex_issue_stage.sv - ID/EX pipeline register with load-use stall and operand bypass
module ex_issue_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int CTRL_W = riscv_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_sr1_sel,
  input  logic              id_sr2_sel,
  input  logic [4:0]        id_rd_addr,
  input  logic              id_rd_wen,
  input  logic              id_is_load,
  input  logic [4:0]        mem_rd_addr,
  input  logic              mem_rd_wen,
  input  logic [XLEN-1:0]   mem_rd_data,
  input  logic [4:0]        wb_rd_addr,
  input  logic              wb_rd_wen,
  input  logic [XLEN-1:0]   wb_rd_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]   alu_sr1,
  output logic [XLEN-1:0]   alu_sr2,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rd_addr,
  output logic              ex_rd_wen,
  output logic              ex_is_load
);
  import riscv_pkg::*;

  logic              valid_q, sr1_sel_q, sr2_sel_q, rd_wen_q, is_load_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [REG_AW-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, pc_q, imm_q;
  logic [XLEN-1:0]   cap_rs1, cap_rs2, hold_rs1, hold_rs2;
  logic              hazard, xfer;

  assign hazard = valid_q && is_load_q &&
                  ((id_rs1_used && addr_hit(id_rs1_addr, rd_addr_q, rd_wen_q)) ||
                   (id_rs2_used && addr_hit(id_rs2_addr, rd_addr_q, rd_wen_q)));
  assign id_ready = (!valid_q || ex_ready) && !hazard;
  assign xfer     = id_valid && id_ready;

  fwd_mux #(.XLEN(XLEN)) u_cap_rs1 (
    .addr(id_rs1_addr), .id_data(id_rs1_data),
    .mem_addr(mem_rd_addr), .mem_wen(mem_rd_wen), .mem_data(mem_rd_data),
    .wb_addr(wb_rd_addr), .wb_wen(wb_rd_wen), .wb_data(wb_rd_data), .data(cap_rs1));

  fwd_mux #(.XLEN(XLEN)) u_cap_rs2 (
    .addr(id_rs2_addr), .id_data(id_rs2_data),
    .mem_addr(mem_rd_addr), .mem_wen(mem_rd_wen), .mem_data(mem_rd_data),
    .wb_addr(wb_rd_addr), .wb_wen(wb_rd_wen), .wb_data(wb_rd_data), .data(cap_rs2));

  // While stalled, a producer retiring past us must still land in the held operands.
  fwd_mux #(.XLEN(XLEN)) u_hold_rs1 (
    .addr(rs1_addr_q), .id_data(rs1_q),
    .mem_addr(mem_rd_addr), .mem_wen(mem_rd_wen), .mem_data(mem_rd_data),
    .wb_addr(wb_rd_addr), .wb_wen(wb_rd_wen), .wb_data(wb_rd_data), .data(hold_rs1));

  fwd_mux #(.XLEN(XLEN)) u_hold_rs2 (
    .addr(rs2_addr_q), .id_data(rs2_q),
    .mem_addr(mem_rd_addr), .mem_wen(mem_rd_wen), .mem_data(mem_rd_data),
    .wb_addr(wb_rd_addr), .wb_wen(wb_rd_wen), .wb_data(wb_rd_data), .data(hold_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      sr1_sel_q  <= 1'b0;
      sr2_sel_q  <= 1'b0;
      rd_wen_q   <= 1'b0;
      is_load_q  <= 1'b0;
    end else if (!flush && xfer) begin
      valid_q    <= 1'b1;
      ctrl_q     <= id_alu_ctrl;
      rs1_addr_q <= id_rs1_addr;
      rs2_addr_q <= id_rs2_addr;
      rd_addr_q  <= id_rd_addr;
      rs1_q      <= cap_rs1;
      rs2_q      <= cap_rs2;
      pc_q       <= id_pc;
      imm_q      <= id_imm;
      sr1_sel_q  <= id_sr1_sel;
      sr2_sel_q  <= id_sr2_sel;
      rd_wen_q   <= id_rd_wen;
      is_load_q  <= id_is_load;
    end else if (flush || !valid_q || ex_ready) begin
      // Empty slot: control side goes to zero so the ALU sees a no-op.
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      rd_wen_q  <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      rs1_q <= hold_rs1;
      rs2_q <= hold_rs2;
    end
  end

  assign ex_valid      = valid_q;
  assign alu_ctrl      = ctrl_q;
  assign alu_sr1       = sr1_sel_q ? pc_q : rs1_q;
  assign alu_sr2       = sr2_sel_q ? imm_q : rs2_q;
  assign ex_store_data = rs2_q;
  assign ex_pc         = pc_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_rd_wen     = rd_wen_q;
  assign ex_is_load    = is_load_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// tb/tb_ex_issue_stage.sv - directed vector bench for ex_issue_stage
module tb_ex_issue_stage;

  localparam int XLEN   = 64;
  localparam int CTRL_W = 17;
  localparam logic [63:0] PC  = 64'h1000;
  localparam logic [63:0] IMM = 64'h20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_ready;
  logic [CTRL_W-1:0] id_alu_ctrl;
  logic [4:0]        id_rs1_addr, id_rs2_addr;
  logic              id_rs1_used, id_rs2_used;
  logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_pc, id_imm;
  logic              id_sr1_sel, id_sr2_sel;
  logic [4:0]        id_rd_addr;
  logic              id_rd_wen, id_is_load;
  logic [4:0]        mem_rd_addr, wb_rd_addr;
  logic              mem_rd_wen, wb_rd_wen;
  logic [XLEN-1:0]   mem_rd_data, wb_rd_data;
  logic              flush, ex_ready;
  logic              ex_valid;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [XLEN-1:0]   alu_sr1, alu_sr2, ex_store_data, ex_pc;
  logic [4:0]        ex_rd_addr;
  logic              ex_rd_wen, ex_is_load;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_issue_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_ctrl(id_alu_ctrl), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_pc(id_pc), .id_imm(id_imm),
    .id_sr1_sel(id_sr1_sel), .id_sr2_sel(id_sr2_sel), .id_rd_addr(id_rd_addr),
    .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
    .mem_rd_addr(mem_rd_addr), .mem_rd_wen(mem_rd_wen), .mem_rd_data(mem_rd_data),
    .wb_rd_addr(wb_rd_addr), .wb_rd_wen(wb_rd_wen), .wb_rd_data(wb_rd_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .alu_ctrl(alu_ctrl),
    .alu_sr1(alu_sr1), .alu_sr2(alu_sr2), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load));

  typedef struct {
    logic              vld;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs1, rs2;
    logic [63:0]       d1, d2;
    logic [1:0]        sel;
    logic [4:0]        rd;
    logic              wen, ld;
    logic [4:0]        ma;
    logic              mw;
    logic [63:0]       md;
    logic [4:0]        wa;
    logic              ww;
    logic [63:0]       wd;
    logic              fl, rdy;
    logic              e_idr, e_v;
    logic [CTRL_W-1:0] e_ctrl;
    logic [63:0]       e_s1, e_s2;
    logic              e_wen;
  } vec_t;

  function automatic vec_t mk(
      logic vld, logic [CTRL_W-1:0] ctrl, logic [4:0] rs1, logic [4:0] rs2,
      logic [63:0] d1, logic [63:0] d2, logic [1:0] sel, logic [4:0] rd, logic wen, logic ld,
      logic [4:0] ma, logic mw, logic [63:0] md, logic [4:0] wa, logic ww, logic [63:0] wd,
      logic fl, logic rdy, logic e_idr, logic e_v, logic [CTRL_W-1:0] e_ctrl,
      logic [63:0] e_s1, logic [63:0] e_s2, logic e_wen);
    vec_t v;
    v.vld = vld; v.ctrl = ctrl; v.rs1 = rs1; v.rs2 = rs2; v.d1 = d1; v.d2 = d2;
    v.sel = sel; v.rd = rd; v.wen = wen; v.ld = ld; v.ma = ma; v.mw = mw; v.md = md;
    v.wa = wa; v.ww = ww; v.wd = wd; v.fl = fl; v.rdy = rdy; v.e_idr = e_idr;
    v.e_v = e_v; v.e_ctrl = e_ctrl; v.e_s1 = e_s1; v.e_s2 = e_s2; v.e_wen = e_wen;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.vld; id_alu_ctrl = v.ctrl; id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
    id_rs1_data = v.d1; id_rs2_data = v.d2; id_sr1_sel = v.sel[1]; id_sr2_sel = v.sel[0];
    id_rd_addr = v.rd; id_rd_wen = v.wen; id_is_load = v.ld;
    mem_rd_addr = v.ma; mem_rd_wen = v.mw; mem_rd_data = v.md;
    wb_rd_addr = v.wa; wb_rd_wen = v.ww; wb_rd_data = v.wd;
    flush = v.fl; ex_ready = v.rdy;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    id_rs1_used = 1'b1; id_rs2_used = 1'b1; id_pc = PC; id_imm = IMM;
    idle();
    rst_n = 1'b0;

    //           vld ctrl    rs1 rs2 d1   d2   sel rd wen ld ma mw md  wa ww wd     fl rdy idr v ctrl    s1  s2    wen
    vecs[0] = mk(1, 17'h1,   1,  2,  100, 200, 0,  3, 1,  0, 1, 1, 5,  1, 1, 9,     0, 1,  1,  1, 17'h1,   5,  200,  1);
    vecs[1] = mk(1, 17'h2,   4,  6,  11,  22,  0,  7, 1,  0, 7, 1, 99, 6, 1, 66,    0, 1,  1,  1, 17'h2,   11, 66,   1);
    vecs[2] = mk(1, 17'h4,   0,  5,  0,   3,   1,  8, 1,  0, 0, 1, 7,  0, 0, 0,     0, 1,  1,  1, 17'h4,   0,  IMM,  1);
    vecs[3] = mk(1, 17'h1,   1,  2,  10,  20,  0,  5, 1,  1, 0, 0, 0,  0, 0, 0,     0, 1,  1,  1, 17'h1,   10, 20,   1);
    vecs[4] = mk(1, 17'h100, 5,  0,  50,  0,   0,  6, 1,  0, 0, 0, 0,  0, 0, 0,     0, 1,  0,  0, 17'h0,   0,  0,    0);
    vecs[5] = mk(1, 17'h100, 5,  0,  50,  0,   0,  6, 1,  0, 0, 0, 0,  0, 0, 0,     0, 1,  1,  1, 17'h100, 50, 0,    1);
    vecs[6] = mk(1, 17'h1,   1,  2,  1,   2,   0,  9, 1,  0, 0, 0, 0,  0, 0, 0,     1, 1,  1,  0, 17'h0,   0,  0,    0);
    vecs[7] = mk(0, 17'h0,   0,  0,  0,   0,   0,  0, 0,  0, 0, 0, 0,  0, 0, 0,     0, 1,  1,  0, 17'h0,   0,  0,    0);

    #12;
    chk("reset ex_valid", 64'(ex_valid), 0);
    chk("reset alu_ctrl", 64'(alu_ctrl), 0);
    chk("reset id_ready", 64'(id_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = vecs[i];
      drive(v);
      #1;
      chk($sformatf("v%0d id_ready", i), 64'(id_ready), 64'(v.e_idr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_valid", i), 64'(ex_valid), 64'(v.e_v));
      chk($sformatf("v%0d alu_ctrl", i), 64'(alu_ctrl), 64'(v.e_ctrl));
      chk($sformatf("v%0d ex_rd_wen", i), 64'(ex_rd_wen), 64'(v.e_wen));
      if (v.e_v) begin
        chk($sformatf("v%0d alu_sr1", i), alu_sr1, v.e_s1);
        chk($sformatf("v%0d alu_sr2", i), alu_sr2, v.e_s2);
      end
    end

    // Stall for three cycles while WB retires x2 in the second one.
    @(negedge clk);
    drive(mk(1, 17'h1, 1, 2, 1, 2, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    idle(); ex_ready = 1'b0;
    #1 chk("stall id_ready", 64'(id_ready), 0);
    @(negedge clk);
    wb_rd_addr = 5'd2; wb_rd_wen = 1'b1; wb_rd_data = 64'h1234;
    @(negedge clk);
    wb_rd_wen = 1'b0; wb_rd_data = 64'h0;
    @(negedge clk);
    chk("stall ex_valid", 64'(ex_valid), 1);
    chk("stall alu_sr2", alu_sr2, 64'h1234);
    chk("stall store_data", ex_store_data, 64'h1234);
    chk("stall alu_sr1", alu_sr1, 64'h1);
    ex_ready = 1'b1;
    @(negedge clk);
    chk("release ex_valid", 64'(ex_valid), 0);

    // Asynchronous reset while a load is held.
    drive(mk(1, 17'h1, 1, 2, 4, 4, 2'b10, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    idle(); ex_ready = 1'b0; id_rs1_addr = 5'd5;
    #1 chk("held id_ready", 64'(id_ready), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst ex_valid", 64'(ex_valid), 0);
    chk("arst alu_ctrl", 64'(alu_ctrl), 0);
    chk("arst ex_is_load", 64'(ex_is_load), 0);
    chk("arst ex_rd_wen", 64'(ex_rd_wen), 0);
    chk("arst ex_rd_addr", 64'(ex_rd_addr), 0);
    chk("arst alu_sr1", alu_sr1, 0);
    chk("arst ex_pc", ex_pc, 0);
    chk("arst id_ready", 64'(id_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1, 17'h2, 5, 0, 77, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    #1 chk("post-reset id_ready", 64'(id_ready), 1);
    @(posedge clk);
    #1;
    chk("post-reset ex_valid", 64'(ex_valid), 1);
    chk("post-reset alu_ctrl", 64'(alu_ctrl), 17'h2);
    chk("post-reset alu_sr1", alu_sr1, 77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
